// File: rtl/rs_superscalar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_superscalar_pkg
//  Description : Shared types and sizing for the superscalar reservation
//                station: entry payload, FU classes, tag type, helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_superscalar_pkg;

    localparam int RS_SIZE        = 16;
    localparam int DISPATCH_WIDTH = 2;
    localparam int CDB_WIDTH      = 2;
    localparam int NUM_FU         = 5;
    localparam int PREG_W         = 6;
    localparam int CNT_W          = $clog2(RS_SIZE) + 1;
    localparam int IDX_W          = $clog2(RS_SIZE);

    typedef logic [PREG_W-1:0] PHYS_REG;

    // Tag used by dispatch for a source that the instruction does not read.
    localparam PHYS_REG DUMMY_REG = '0;

    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_MULT = 3'd1,
        FU_LD   = 3'd2,
        FU_ST   = 3'd3,
        FU_BR   = 3'd4
    } FU_NAME;

    typedef struct packed {
        logic        busy;
        logic [31:0] inst;
        FU_NAME      fu_name;
        PHYS_REG     T;
        PHYS_REG     T1;
        PHYS_REG     T2;
        logic        T1_rdy;
        logic        T2_rdy;
    } RS_ENTRY_T;

    // True when any valid CDB lane carries the given tag.
    function automatic logic cdb_hit(input PHYS_REG                  tag,
                                     input logic [CDB_WIDTH-1:0]     vld,
                                     input PHYS_REG [CDB_WIDTH-1:0]  tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_WIDTH; c++) begin
            if (vld[c] && (tags[c] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [RS_SIZE-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_select
//  Description : Picks the oldest requester using an age matrix.
//                older_i[j][i] = 1 means entry j is older than entry i.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_age_select #(
    parameter int N = 16
) (
    input  logic [N-1:0]        req_i,
    input  logic [N-1:0][N-1:0] older_i,
    output logic [N-1:0]        grant_o
);

    logic [N-1:0] blocked;

    // A requester wins only if no other requester is older than it.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (req_i[j] && older_i[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        grant_o = req_i & ~blocked;
    end

endmodule
`default_nettype wire

// File: rtl/rs_superscalar.sv
`default_nettype none
// ============================================================================
//  Module      : rs_superscalar
//  Description : N-way reservation station. Multi-lane dispatch into the
//                lowest free slots, CDB wakeup (including same-cycle wakeup
//                of dispatching lanes), oldest-ready issue per FU class via
//                an age matrix, and full flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_superscalar
    import rs_superscalar_pkg::*;
(
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                enable_i,
    input  logic                                flush_i,
    input  logic [DISPATCH_WIDTH-1:0]           dispatch_valid_i,
    input  RS_ENTRY_T [DISPATCH_WIDTH-1:0]      inst_in_i,
    input  logic [CDB_WIDTH-1:0]                cdb_valid_i,
    input  PHYS_REG [CDB_WIDTH-1:0]             cdb_tag_i,
    input  logic [NUM_FU-1:0]                   fu_stall_i,
    output logic [NUM_FU-1:0]                   issue_valid_o,
    output RS_ENTRY_T [NUM_FU-1:0]              issue_next_o,
    output logic [CNT_W-1:0]                    free_count_o,
    output logic                                rs_full_o
`ifdef DEBUG
    ,
    output RS_ENTRY_T [RS_SIZE-1:0]             rs_table_out_o
`endif
);

    localparam logic [CNT_W-1:0] FREE_ALL = CNT_W'(RS_SIZE);
    localparam logic [CNT_W-1:0] DW_CNT   = CNT_W'(DISPATCH_WIDTH);

    RS_ENTRY_T [RS_SIZE-1:0]          entries_q, entries_d;
    logic [RS_SIZE-1:0][RS_SIZE-1:0]  older_q, older_d;
    logic [CNT_W-1:0]                 free_count_q, free_count_d;

    logic [NUM_FU-1:0][RS_SIZE-1:0]   fu_req;
    logic [NUM_FU-1:0][RS_SIZE-1:0]   fu_grant;
    logic [RS_SIZE-1:0]               issued;
    logic                             accept;
    logic [RS_SIZE-1:0]               free_scan;
    logic [DISPATCH_WIDTH-1:0]        alloc_valid;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] alloc_idx;
    RS_ENTRY_T                        dispatch_e;

    assign free_count_o = free_count_q;
    assign rs_full_o    = (free_count_q < DW_CNT);
    // Flush wins over dispatch; a full RS drops every lane.
    assign accept       = enable_i && !rs_full_o && !flush_i;

`ifdef DEBUG
    assign rs_table_out_o = entries_q;
`endif

    // Per-class request masks from registered state only (no wake-and-issue).
    always_comb begin
        fu_req = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                fu_req[f][i] = entries_q[i].busy && entries_q[i].T1_rdy &&
                               entries_q[i].T2_rdy && enable_i && !fu_stall_i[f] &&
                               (entries_q[i].fu_name == FU_NAME'(f));
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu_select
        rs_age_select #(
            .N (RS_SIZE)
        ) u_age_select (
            .req_i   (fu_req[f]),
            .older_i (older_q),
            .grant_o (fu_grant[f])
        );
    end

    // Mux granted entries onto issue ports; classes are disjoint so no entry
    // can appear on two ports.
    always_comb begin
        issued       = '0;
        issue_next_o = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            issue_valid_o[f] = |fu_grant[f];
            for (int i = 0; i < RS_SIZE; i++) begin
                if (fu_grant[f][i]) begin
                    issue_next_o[f] = entries_q[i];
                end
            end
            issued = issued | fu_grant[f];
        end
    end

    // Give each valid lane, in lane order, the lowest slot free at the start
    // of the cycle; slots freed by this cycle's issue are not reused yet.
    always_comb begin
        alloc_valid = '0;
        alloc_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_scan[i] = !entries_q[i].busy;
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (accept && dispatch_valid_i[k]) begin
                for (int i = RS_SIZE - 1; i >= 0; i--) begin
                    if (free_scan[i]) begin
                        alloc_idx[k]   = IDX_W'(i);
                        alloc_valid[k] = 1'b1;
                    end
                end
                if (alloc_valid[k]) begin
                    free_scan[alloc_idx[k]] = 1'b0;
                end
            end
        end
    end

    // Next state: flush, issue retirement, wakeup, then dispatch writes and
    // age update (each new entry is younger than everything already present).
    always_comb begin
        entries_d    = entries_q;
        older_d      = older_q;
        free_count_d = free_count_q;
        dispatch_e   = '0;
        if (flush_i) begin
            entries_d    = '0;
            older_d      = '0;
            free_count_d = FREE_ALL;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (issued[i]) begin
                    entries_d[i].busy = 1'b0;
                end
                if (entries_q[i].busy) begin
                    if (cdb_hit(entries_q[i].T1, cdb_valid_i, cdb_tag_i)) begin
                        entries_d[i].T1_rdy = 1'b1;
                    end
                    if (cdb_hit(entries_q[i].T2, cdb_valid_i, cdb_tag_i)) begin
                        entries_d[i].T2_rdy = 1'b1;
                    end
                end
            end
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (alloc_valid[k]) begin
                    dispatch_e        = inst_in_i[k];
                    dispatch_e.busy   = 1'b1;
                    dispatch_e.T1_rdy = inst_in_i[k].T1_rdy ||
                                        cdb_hit(inst_in_i[k].T1, cdb_valid_i, cdb_tag_i);
                    dispatch_e.T2_rdy = inst_in_i[k].T2_rdy ||
                                        cdb_hit(inst_in_i[k].T2, cdb_valid_i, cdb_tag_i);
                    entries_d[alloc_idx[k]] = dispatch_e;
                    for (int j = 0; j < RS_SIZE; j++) begin
                        older_d[j][alloc_idx[k]] = 1'b1;
                    end
                    older_d[alloc_idx[k]] = '0;
                end
            end
            free_count_d = free_count_q - popcount(RS_SIZE'(alloc_valid)) + popcount(issued);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            entries_q    <= '0;
            older_q      <= '0;
            free_count_q <= FREE_ALL;
        end else begin
            entries_q    <= entries_d;
            older_q      <= older_d;
            free_count_q <= free_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_superscalar.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_superscalar
//  Description : Directed self-checking bench for rs_superscalar.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_superscalar;
    import rs_superscalar_pkg::*;

    localparam int ALU  = 0;
    localparam int MULT = 1;
    localparam int LD   = 2;

    logic                          clock = 1'b0;
    logic                          reset;
    logic                          enable;
    logic                          flush;
    logic [DISPATCH_WIDTH-1:0]     dispatch_valid;
    RS_ENTRY_T [DISPATCH_WIDTH-1:0] inst_in;
    logic [CDB_WIDTH-1:0]          cdb_valid;
    PHYS_REG [CDB_WIDTH-1:0]       cdb_tag;
    logic [NUM_FU-1:0]             fu_stall;
    logic [NUM_FU-1:0]             issue_valid;
    RS_ENTRY_T [NUM_FU-1:0]        issue_next;
    logic [CNT_W-1:0]              free_count;
    logic                          rs_full;

    int errors = 0;
    int checks = 0;

    rs_superscalar dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .enable_i         (enable),
        .flush_i          (flush),
        .dispatch_valid_i (dispatch_valid),
        .inst_in_i        (inst_in),
        .cdb_valid_i      (cdb_valid),
        .cdb_tag_i        (cdb_tag),
        .fu_stall_i       (fu_stall),
        .issue_valid_o    (issue_valid),
        .issue_next_o     (issue_next),
        .free_count_o     (free_count),
        .rs_full_o        (rs_full)
    );

    always #5 clock = ~clock;

    function automatic RS_ENTRY_T mk(input FU_NAME fu, input PHYS_REG t,
                                     input PHYS_REG t1, input logic r1,
                                     input PHYS_REG t2, input logic r2);
        RS_ENTRY_T e;
        e         = '0;
        e.inst    = 32'hA000_0000 | 32'(t);
        e.fu_name = fu;
        e.T       = t;
        e.T1      = t1;
        e.T1_rdy  = r1;
        e.T2      = t2;
        e.T2_rdy  = r2;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        dispatch_valid = '0;
        cdb_valid      = '0;
        flush          = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL reset_free: got %0d expected 16", free_count); end
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", rs_full); end
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL reset_issue: got %b expected 00000", issue_valid); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_alu();
        dispatch_valid = 2'b01;
        inst_in[0]     = mk(FU_ALU, 6'h05, 6'h03, 1'b1, 6'h04, 1'b1);
        #1;
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL single_pre: got %b expected 00000", issue_valid); end
        tick(); idle(); #1;
        checks++; if (issue_valid !== 5'b00001) begin errors++; $display("FAIL single_valid: got %b expected 00001", issue_valid); end
        checks++; if (issue_next[ALU].T !== 6'h05) begin errors++; $display("FAIL single_T: got %h expected 05", issue_next[ALU].T); end
        checks++; if (free_count !== 5'd15) begin errors++; $display("FAIL single_free1: got %0d expected 15", free_count); end
        tick();
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL single_free2: got %0d expected 16", free_count); end
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL single_post: got %b expected 00000", issue_valid); end
    endtask

    task automatic test_wakeup_latency();
        dispatch_valid = 2'b01;
        inst_in[0]     = mk(FU_ALU, 6'h05, 6'h01, 1'b1, 6'h02, 1'b1);
        tick(); idle();
        dispatch_valid = 2'b01;
        inst_in[0]     = mk(FU_ALU, 6'h06, 6'h05, 1'b0, 6'h03, 1'b1);
        tick(); idle(); #1;
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL wake_wait: got %b expected 00000", issue_valid); end
        cdb_valid  = 2'b01;
        cdb_tag[0] = 6'h05;
        #1;
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL wake_same_cycle: got %b expected 00000", issue_valid); end
        tick(); idle(); #1;
        checks++; if (issue_valid !== 5'b00001) begin errors++; $display("FAIL wake_issue: got %b expected 00001", issue_valid); end
        checks++; if (issue_next[ALU].T !== 6'h06) begin errors++; $display("FAIL wake_T: got %h expected 06", issue_next[ALU].T); end
        tick();
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL wake_free: got %0d expected 16", free_count); end
    endtask

    task automatic test_stall_order();
        fu_stall[MULT] = 1'b1;
        dispatch_valid = 2'b11;
        inst_in[0]     = mk(FU_ALU,  6'h20, 6'h30, 1'b0, 6'h01, 1'b1);
        inst_in[1]     = mk(FU_MULT, 6'h10, 6'h01, 1'b1, 6'h02, 1'b1);
        tick(); idle(); #1;
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL stall_hold1: got %b expected 00000", issue_valid); end
        checks++; if (free_count !== 5'd14) begin errors++; $display("FAIL stall_free1: got %0d expected 14", free_count); end
        cdb_valid  = 2'b01;
        cdb_tag[0] = 6'h30;
        tick(); idle(); #1;
        checks++; if (issue_valid !== 5'b00001) begin errors++; $display("FAIL stall_hold2: got %b expected 00001", issue_valid); end
        checks++; if (issue_next[ALU].T !== 6'h20) begin errors++; $display("FAIL stall_aluT: got %h expected 20", issue_next[ALU].T); end
        tick(); #1;
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL stall_hold3: got %b expected 00000", issue_valid); end
        // B lands in the lower slot just freed, yet is younger than A.
        dispatch_valid = 2'b01;
        inst_in[0]     = mk(FU_MULT, 6'h11, 6'h01, 1'b1, 6'h02, 1'b1);
        tick(); idle(); #1;
        checks++; if (free_count !== 5'd14) begin errors++; $display("FAIL stall_free2: got %0d expected 14", free_count); end
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL stall_hold4: got %b expected 00000", issue_valid); end
        fu_stall[MULT] = 1'b0;
        #1;
        checks++; if (issue_valid !== 5'b00010) begin errors++; $display("FAIL stall_relA_v: got %b expected 00010", issue_valid); end
        checks++; if (issue_next[MULT].T !== 6'h10) begin errors++; $display("FAIL stall_relA_T: got %h expected 10", issue_next[MULT].T); end
        tick();
        checks++; if (issue_valid !== 5'b00010) begin errors++; $display("FAIL stall_relB_v: got %b expected 00010", issue_valid); end
        checks++; if (issue_next[MULT].T !== 6'h11) begin errors++; $display("FAIL stall_relB_T: got %h expected 11", issue_next[MULT].T); end
        tick();
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL stall_done: got %b expected 00000", issue_valid); end
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL stall_free3: got %0d expected 16", free_count); end
    endtask

    task automatic test_same_cycle_wake();
        dispatch_valid = 2'b11;
        inst_in[0]     = mk(FU_ALU, 6'h08, 6'h01, 1'b1, 6'h02, 1'b1);
        inst_in[1]     = mk(FU_LD,  6'h09, 6'h07, 1'b0, 6'h02, 1'b1);
        cdb_valid      = 2'b10;
        cdb_tag[0]     = 6'h3B;
        cdb_tag[1]     = 6'h07;
        tick(); idle(); #1;
        checks++; if (issue_valid !== 5'b00101) begin errors++; $display("FAIL samecyc_v: got %b expected 00101", issue_valid); end
        checks++; if (issue_next[LD].T !== 6'h09) begin errors++; $display("FAIL samecyc_T: got %h expected 09", issue_next[LD].T); end
        checks++; if (issue_next[LD].T1_rdy !== 1'b1) begin errors++; $display("FAIL samecyc_rdy: got %b expected 1", issue_next[LD].T1_rdy); end
        tick();
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL samecyc_free: got %0d expected 16", free_count); end
    endtask

    task automatic test_enable();
        enable         = 1'b0;
        dispatch_valid = 2'b01;
        inst_in[0]     = mk(FU_ALU, 6'h33, 6'h01, 1'b1, 6'h02, 1'b1);
        tick(); idle();
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL en_nodisp: got %0d expected 16", free_count); end
        enable         = 1'b1;
        dispatch_valid = 2'b01;
        inst_in[0]     = mk(FU_ALU, 6'h31, 6'h22, 1'b0, 6'h02, 1'b1);
        tick(); idle();
        enable     = 1'b0;
        cdb_valid  = 2'b01;
        cdb_tag[0] = 6'h22;
        tick(); idle(); #1;
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL en_noissue: got %b expected 00000", issue_valid); end
        checks++; if (free_count !== 5'd15) begin errors++; $display("FAIL en_free: got %0d expected 15", free_count); end
        enable = 1'b1;
        #1;
        checks++; if (issue_valid !== 5'b00001) begin errors++; $display("FAIL en_woken_v: got %b expected 00001", issue_valid); end
        checks++; if (issue_next[ALU].T !== 6'h31) begin errors++; $display("FAIL en_woken_T: got %h expected 31", issue_next[ALU].T); end
        tick();
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL en_free2: got %0d expected 16", free_count); end
    endtask

    task automatic test_full();
        for (int c = 0; c < 7; c++) begin
            dispatch_valid = 2'b11;
            inst_in[0]     = mk(FU_ALU, 6'(16 + 2 * c),     6'h2A, 1'b0, 6'h01, 1'b1);
            inst_in[1]     = mk(FU_ALU, 6'(16 + 2 * c + 1), 6'h2A, 1'b0, 6'h01, 1'b1);
            tick();
        end
        dispatch_valid = 2'b01;
        inst_in[0]     = mk(FU_ALU, 6'h1E, 6'h2A, 1'b0, 6'h01, 1'b1);
        tick(); idle();
        checks++; if (free_count !== 5'd1) begin errors++; $display("FAIL full_free: got %0d expected 1", free_count); end
        checks++; if (rs_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", rs_full); end
        dispatch_valid = 2'b11;
        inst_in[0]     = mk(FU_ALU, 6'h3E, 6'h01, 1'b1, 6'h02, 1'b1);
        inst_in[1]     = mk(FU_ALU, 6'h3F, 6'h01, 1'b1, 6'h02, 1'b1);
        tick(); idle(); #1;
        checks++; if (free_count !== 5'd1) begin errors++; $display("FAIL full_drop: got %0d expected 1", free_count); end
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL full_noissue: got %b expected 00000", issue_valid); end
        cdb_valid  = 2'b01;
        cdb_tag[0] = 6'h2A;
        tick(); idle(); #1;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (issue_valid[ALU] !== 1'b1 || issue_next[ALU].T !== 6'(16 + i)) begin
                errors++;
                $display("FAIL full_drain[%0d]: got v=%b T=%h expected v=1 T=%h",
                         i, issue_valid[ALU], issue_next[ALU].T, 6'(16 + i));
            end
            tick();
        end
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL full_free2: got %0d expected 16", free_count); end
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL full_flag2: got %b expected 0", rs_full); end
    endtask

    task automatic test_flush();
        dispatch_valid = 2'b11;
        inst_in[0]     = mk(FU_ALU,  6'h12, 6'h15, 1'b0, 6'h01, 1'b1);
        inst_in[1]     = mk(FU_MULT, 6'h13, 6'h15, 1'b0, 6'h01, 1'b1);
        tick(); idle();
        flush          = 1'b1;
        dispatch_valid = 2'b11;
        inst_in[0]     = mk(FU_ALU, 6'h14, 6'h01, 1'b1, 6'h02, 1'b1);
        inst_in[1]     = mk(FU_LD,  6'h16, 6'h01, 1'b1, 6'h02, 1'b1);
        cdb_valid      = 2'b01;
        cdb_tag[0]     = 6'h15;
        tick(); idle(); #1;
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL flush_free: got %0d expected 16", free_count); end
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL flush_issue: got %b expected 00000", issue_valid); end
        tick();
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL flush_issue2: got %b expected 00000", issue_valid); end
    endtask

    task automatic test_async_reset();
        dispatch_valid = 2'b01;
        inst_in[0]     = mk(FU_ALU, 6'h3C, 6'h01, 1'b1, 6'h02, 1'b1);
        tick(); idle(); #1;
        checks++; if (issue_valid !== 5'b00001) begin errors++; $display("FAIL arst_pre: got %b expected 00001", issue_valid); end
        reset = 1'b1;
        #1;
        checks++; if (issue_valid !== 5'b0) begin errors++; $display("FAIL arst_issue: got %b expected 00000", issue_valid); end
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL arst_free: got %0d expected 16", free_count); end
        #1;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        flush          = 1'b0;
        dispatch_valid = '0;
        inst_in        = '0;
        cdb_valid      = '0;
        cdb_tag        = '0;
        fu_stall       = '0;
        test_reset();
        test_single_alu();
        test_wakeup_latency();
        test_stall_order();
        test_same_cycle_wake();
        test_enable();
        test_full();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
